ripple_sum_deserializer: RTL
============================

# ripple_sum_deserializer

Downstream collector for the bit-serial output of `ripple_carry_8bit`. It samples the LSB-first `sum` stream one bit per accepted beat and assembles `WIDTH` bits into a parallel word. It captures `cout` on the final bit and presents word plus carry on a valid/ready output port. A one-word output buffer lets the next word assemble while the previous one waits to be drained.

## Interface
- `WIDTH`, default `ADDER_WIDTH` (8): number of sum bits per word; legal range 2..32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: `in_sum`/`in_cout` carry a bit this cycle.
- `in_ready` out 1: block accepts the bit this cycle.
- `in_sum` in 1: `sum` output of the adder stage, LSB first.
- `in_cout` in 1: `cout` of the adder stage; sampled only on the final bit.
- `in_flush` in 1: discard the partially assembled word.
- `out_valid` out 1: `out_data`/`out_cout` hold a complete word.
- `out_ready` in 1: consumer takes the word this cycle.
- `out_data` out `WIDTH`: assembled sum word, bit 0 = first accepted bit.
- `out_cout` out 1: carry-out of the word.

## Operation
- Beat: `in_valid && in_ready`. Drain: `out_valid && out_ready`.
- State: `bit_cnt` (`$clog2(WIDTH)` bits), `partial` (`WIDTH-1` bits), output register {`out_data`, `out_cout`, `out_valid`}.
- Non-final beat (`bit_cnt < WIDTH-1`):
  - `partial[bit_cnt] <= in_sum`.
  - `bit_cnt` increments.
  - `in_cout` is ignored.
- Final beat (`bit_cnt == WIDTH-1`):
  - `out_data <= {in_sum, partial}`, `out_cout <= in_cout`, `out_valid <= 1`.
  - `bit_cnt <= 0`, `partial <= 0`.
- `in_ready = !(bit_cnt == WIDTH-1 && out_valid && !out_ready)`.
  - Only the final bit can stall.
  - `in_ready` depends combinationally on `out_ready`.
- Drain with no final beat in the same cycle: `out_valid <= 0`. `out_data` and `out_cout` keep their value.
- Drain and final beat in the same cycle: the new word loads and `out_valid` stays 1. No bubble, no loss.
- `in_flush` has priority over a beat in the same cycle:
  - The beat is dropped.
  - `bit_cnt <= 0`, `partial <= 0`.
  - The output register and `out_valid` are unaffected.
- Reset (any cycle, including mid-word or while the output is held):
  - `bit_cnt = 0`, `partial = 0`.
  - `out_valid = 0`, `out_data = 0`, `out_cout = 0`.
  - `in_ready = 1` in the first cycle after reset.
- `bit_cnt` wraps from `WIDTH-1` to 0 only through a final beat or flush. It never counts past `WIDTH-1`.

## Timing
- Latency: `out_valid` rises on the edge that accepts the final bit. The word is visible the cycle after that beat.
- Throughput: one bit per cycle, one word per `WIDTH` cycles sustained with `out_ready` held at 1.
- The output register holds stable while `out_valid && !out_ready`.
- Stall: with the output full and not draining, the final bit is held off. `in_ready` is 0 until the cycle in which `out_ready = 1`, and the final bit is accepted in that same cycle.
- No combinational path from `in_*` to `out_*`. The only combinational path is `out_ready` to `in_ready`.

## Structure
- Shared package `ripple_pkg`: `ADDER_WIDTH = 8`, plus the `$clog2`-derived count width as a localparam function, for reuse by the upstream serializer and the bench.
- Single module, no sub-modules. Counter, shift storage and output buffer are inline.

## Test plan
- Reset, then stream 0x5A LSB first (0,1,0,1,1,0,1,0) with `in_cout` = 1 on bit 7 and `out_ready` = 1 → `out_data` = 0x5A, `out_cout` = 1, `out_valid` high for exactly one cycle, starting the cycle after the 8th beat.
- Back-to-back words 0x01, 0x80, 0xFF with continuous `in_valid` and `out_ready` = 1 → three words spaced 8 cycles apart, `in_ready` never low.
- Word 0x3C with `out_ready` = 0, then word 0xC3 → `in_ready` low at `bit_cnt` = 7. Raise `out_ready` → 0x3C drains, 0xC3 loads the same cycle, `out_valid` never drops.
- 3 bits (1,1,1), then `in_flush` asserted together with a valid beat, then 0x00 with `in_cout` = 0 → `out_data` = 0x00, `out_cout` = 0. The flushed beat and the earlier bits leave no trace.
- Reset mid-word after 5 bits while `out_valid` = 1 → all outputs 0 and `in_ready` = 1 next cycle. The following 0xA5 is assembled correctly.
- `in_cout` toggling on bits 0..6, 0 on bit 7, word 0x7F → `out_cout` = 0.

Source files
------------

// File: rtl/ripple_pkg.sv
// Shared constants for the ripple-carry adder datapath: adder width and the
// bit-counter width helper used by serializer, deserializer and benches.
package ripple_pkg;
  localparam int ADDER_WIDTH = 8;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

  localparam int ADDER_CNT_W = cnt_w(ADDER_WIDTH);
endpackage

// File: rtl/ripple_sum_deserializer.sv
// Collects the LSB-first sum stream of the ripple adder into WIDTH-bit words,
// capturing cout on the last bit, behind a one-word valid/ready output buffer.
module ripple_sum_deserializer
  import ripple_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sum,
  input  logic             in_cout,
  input  logic             in_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-2:0] partial_q, partial_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_cout_q, out_cout_d;
  logic             out_valid_q, out_valid_d;

  logic is_last, beat, drain, final_beat;

  assign is_last    = (bit_cnt_q == LAST);
  // Only the final bit needs the output slot, so only it can be stalled.
  assign in_ready   = !(is_last && out_valid_q && !out_ready);
  assign beat       = in_valid && in_ready && !in_flush;
  assign drain      = out_valid_q && out_ready;
  assign final_beat = beat && is_last;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    partial_d   = partial_q;
    out_data_d  = out_data_q;
    out_cout_d  = out_cout_q;
    out_valid_d = out_valid_q;
    if (in_flush) begin
      bit_cnt_d = '0;
      partial_d = '0;
    end else if (final_beat) begin
      out_data_d = {in_sum, partial_q};
      out_cout_d = in_cout;
      bit_cnt_d  = '0;
      partial_d  = '0;
    end else if (beat) begin
      partial_d[bit_cnt_q] = in_sum;
      bit_cnt_d            = bit_cnt_q + CW'(1);
    end
    // A load in the same cycle as a drain keeps valid high with no bubble.
    if (final_beat)  out_valid_d = 1'b1;
    else if (drain)  out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      partial_q   <= '0;
      out_data_q  <= '0;
      out_cout_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      partial_q   <= partial_d;
      out_data_q  <= out_data_d;
      out_cout_q  <= out_cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_cout  = out_cout_q;
  assign out_valid = out_valid_q;
endmodule
